// File: rtl/event_indicator_pkg.sv
// rtl/event_indicator_pkg.sv - shared FSM encodings and width helper for event_indicator
//
// Purpose : state encodings for the blink FSM and a constant function that
//           returns the number of bits needed to hold a value. The top uses
//           that function to check parameter legality at elaboration.
// Ports   : none (package)
package event_indicator_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    // Bits required to represent value (0 -> 0, 1 -> 1, 2..3 -> 2, ...).
    function automatic int unsigned width_of(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((value >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - up-counter with clear and terminal-count compare
//
// Purpose : counts clock cycles from zero; o_done is high in the cycle the
//           count equals i_last (the interval length minus one). The owner
//           clears the counter on the terminal cycle, so it never wraps.
// Ports   : clk     - system clock
//           reset_n - asynchronous active-low reset
//           i_clear - load zero on the next edge (wins over increment)
//           i_last  - terminal count, selected at runtime by the owner
//           o_done  - count == i_last
module interval_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_last,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == i_last);

endmodule

// File: rtl/event_indicator.sv
// rtl/event_indicator.sv - stretches single-cycle event strobes into visible LED blinks
//
// Purpose : each event produces one blink of ON_CYCLES high followed by at
//           least OFF_CYCLES low. Events arriving mid-blink are queued in a
//           saturating counter and replayed back to back; a dropped event
//           sets a sticky overflow flag.
// Ports   : clk            - system clock
//           reset_n        - asynchronous active-low reset
//           event_pulse    - event strobe, one event per high cycle
//           clear_overflow - synchronous clear of overflow (a drop wins)
//           indicator      - LED drive, registered
//           busy           - high while in ON or OFF, registered
//           pending_count  - queued events not yet blinked
//           overflow       - sticky, set when an event is dropped
module event_indicator
    import event_indicator_pkg::*;
#(
    parameter int ON_CYCLES     = 50000,
    parameter int OFF_CYCLES    = 50000,
    parameter int COUNTER_WIDTH = 16,
    parameter int PENDING_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     event_pulse,
    input  logic                     clear_overflow,
    output logic                     indicator,
    output logic                     busy,
    output logic [PENDING_WIDTH-1:0] pending_count,
    output logic                     overflow
);

    if (ON_CYCLES < 1 || width_of(ON_CYCLES) > COUNTER_WIDTH) begin : g_bad_on_cycles
        $error("event_indicator: ON_CYCLES out of range for COUNTER_WIDTH");
    end
    if (OFF_CYCLES < 1 || width_of(OFF_CYCLES) > COUNTER_WIDTH) begin : g_bad_off_cycles
        $error("event_indicator: OFF_CYCLES out of range for COUNTER_WIDTH");
    end

    localparam logic [COUNTER_WIDTH-1:0] ON_LAST     = COUNTER_WIDTH'(ON_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] OFF_LAST    = COUNTER_WIDTH'(OFF_CYCLES - 1);
    localparam logic [PENDING_WIDTH-1:0] PENDING_MAX = '1;

    logic [1:0]               r_state;
    logic                     r_indicator;
    logic                     r_busy;
    logic [PENDING_WIDTH-1:0] r_pending;
    logic                     r_overflow;

    logic [1:0]               w_next_state;
    logic [COUNTER_WIDTH-1:0] w_last;
    logic                     w_timer_clear;
    logic                     w_timer_done;
    logic                     w_active;
    logic                     w_has_pending;
    logic                     w_off_exit;
    logic                     w_inc;
    logic                     w_dec;
    logic                     w_drop;

    assign w_last        = (r_state == ST_ON) ? ON_LAST : OFF_LAST;
    // Hold the counter at zero while idle and restart it at every phase change.
    assign w_timer_clear = !w_active || w_timer_done;

    interval_timer #(
        .WIDTH(COUNTER_WIDTH)
    ) u_interval_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_timer_clear),
        .i_last  (w_last),
        .o_done  (w_timer_done)
    );

    assign w_active      = (r_state == ST_ON) || (r_state == ST_OFF);
    assign w_has_pending = (r_pending != '0);
    assign w_off_exit    = (r_state == ST_OFF) && w_timer_done;
    assign w_dec         = w_off_exit && w_has_pending;
    // At an OFF exit with an empty queue the event starts the next blink
    // directly instead of being queued.
    assign w_inc         = event_pulse && w_active && !(w_off_exit && !w_has_pending);
    // With a simultaneous decrement the count does not move, so nothing drops.
    assign w_drop        = w_inc && !w_dec && (r_pending == PENDING_MAX);

    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next_state = event_pulse ? ST_ON : ST_IDLE;
            ST_ON:   w_next_state = w_timer_done ? ST_OFF : ST_ON;
            ST_OFF: begin
                if (!w_timer_done) begin
                    w_next_state = ST_OFF;
                end else if (w_has_pending || event_pulse) begin
                    w_next_state = ST_ON;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_indicator <= 1'b0;
            r_busy      <= 1'b0;
            r_pending   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            // Outputs are registered from the next state so they change on
            // the same edge as the FSM.
            r_indicator <= (w_next_state == ST_ON);
            r_busy      <= (w_next_state != ST_IDLE);
            if (w_inc && !w_dec && (r_pending != PENDING_MAX)) begin
                r_pending <= r_pending + 1'b1;
            end else if (w_dec && !w_inc) begin
                r_pending <= r_pending - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign indicator     = r_indicator;
    assign busy          = r_busy;
    assign pending_count = r_pending;
    assign overflow      = r_overflow;

endmodule

// File: doc/event_indicator.md
# event_indicator

Converts single-cycle internal event strobes, such as a button edge, an instruction fetch or a halt, into human-visible blinks on an LED output. It works as the output-side counterpart of input conditioning: short internal pulses become long, regular pulses with guaranteed minimum on-time and off-time. Events that arrive while a blink is in progress are queued and replayed, so N events give N distinct blinks, up to a saturation limit. It sits between core status strobes and the board LED pins.

## Interface
- `ON_CYCLES`, default 50000: indicator-high duration in clk cycles; must be ≥1 and ≤ 2^COUNTER_WIDTH−1.
- `OFF_CYCLES`, default 50000: mandatory low gap after each blink; must be ≥1 and ≤ 2^COUNTER_WIDTH−1.
- `COUNTER_WIDTH`, default 16: width of the interval counter.
- `PENDING_WIDTH`, default 4: width of the queued-event counter; saturates at 2^PENDING_WIDTH−1.
- `clk` in 1: single system clock; all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `event_pulse` in 1: event strobe, synchronous to clk; each high cycle counts as one event.
- `clear_overflow` in 1: synchronous clear of `overflow`.
- `indicator` out 1: LED drive, registered.
- `busy` out 1: high in ON or OFF state, registered.
- `pending_count` out PENDING_WIDTH: queued events not yet blinked, registered.
- `overflow` out 1: sticky flag, set when an event is dropped at saturation.

## Operation
- FSM states: IDLE, ON, OFF. Encoding constants live in the shared package.
- **IDLE:** on `event_pulse`, go to ON and clear the interval counter. Otherwise stay in IDLE.
- **ON:** `indicator` = 1. The counter increments each cycle. At count ON_CYCLES−1, go to OFF and clear the counter.
- **OFF:** `indicator` = 0. At count OFF_CYCLES−1:
  - if `pending_count` > 0, decrement it and go to ON;
  - else, if `event_pulse` is high that cycle, go to ON without touching pending;
  - else go to IDLE.
- **Events in ON/OFF** (outside the OFF exit cases above) increment `pending_count`.
  - At saturation the count holds and `overflow` is set.
- **Simultaneous event and pending decrement** at OFF exit: `pending_count` is unchanged (the two cancel).
- **`clear_overflow` together with a dropping event in the same cycle:** set wins, so `overflow` stays 1.
- **Reset values:** state IDLE, `indicator` 0, `busy` 0, `pending_count` 0, `overflow` 0, counter 0.
- **Reset mid-blink:** `indicator` drops immediately and asynchronously, and the queue is discarded.
- **Interval counter:** unsigned, never wraps, because the terminal compare precedes overflow. Parameter legality is checked at elaboration.

## Timing
- **Blink start latency:** `event_pulse` high at edge k (FSM in IDLE) → `indicator` = 1 from edge k+1.
- **Blink length:** `indicator` high for exactly ON_CYCLES cycles, then low for at least OFF_CYCLES cycles.
- **Back-to-back blinks:** ON restarts exactly OFF_CYCLES cycles after the previous falling edge. The blink period is ON_CYCLES+OFF_CYCLES.
- **`busy`:** rises together with `indicator`. Falls on the edge the FSM enters IDLE, which is OFF_CYCLES cycles after `indicator` falls.
- **Register update timing:** `pending_count` and `overflow` update on the edge following the triggering event.
- **Event in the last OFF cycle with empty queue:** the next ON begins on the following edge. No extra idle cycle is inserted.

## Structure
- Shared package holds the FSM state encodings and a clog2-style width helper.
- One natural sub-module: `interval_timer`, with a clear input, terminal-count compare against a runtime limit (ON_CYCLES or OFF_CYCLES selected by state), and `done` output.
- Pending counter and overflow logic stay in the top module.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=3, PENDING_WIDTH=2.

- **Reset check:** assert `reset_n`=0 mid-ON → `indicator`, `busy`, `pending_count`, `overflow` all 0 immediately. After release, IDLE with no spurious blink.
- **Single event:** one-cycle pulse at cycle 10 → `indicator` high cycles 11–14, low from 15. `busy` low from cycle 18.
- **Queued events:** 3 pulses at cycles 10, 12, 13 → `pending_count` reads 1 then 2. Three blinks start at 11, 18, 25, and the queue drains to 0.
- **Saturation:** 5 pulses during one blink → `pending_count` saturates at 3 and `overflow`=1. Total blinks = 4. `clear_overflow` then clears the flag.
- **Last-OFF-cycle event with empty queue:** pulse in the last OFF cycle → ON restarts on the next edge and `pending_count` stays 0.
- **OFF-exit collision:** event coincident with a pending decrement at OFF exit → `pending_count` unchanged. Also drive `clear_overflow` in the same cycle as a dropping event → `overflow` stays 1.
